// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM states and width defaults for the
// MIPS multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_XLEN = 32;
    localparam int MD_OPW  = 4;

    typedef enum logic [MD_OPW-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } md_state_e;

    function automatic int md_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Datapath for the mul/div sequencer: shift-add product accumulator,
// restoring-divide partial remainder and the final sign fix-up.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic             is_div,
    input  logic             neg_q,
    input  logic             neg_r,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] dvd_o
);

    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   b_q, b_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     part;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH-1:0]   quo_n;
    logic [WIDTH-1:0]   rem_n;

    always_comb begin
        addend = acc_q[0] ? b_q : '0;
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Partial remainder is one bit wider than the divisor.
        part   = {rem_q, acc_q[WIDTH-1]};
        ge     = part >= {1'b0, b_q};
        diff   = part[WIDTH-1:0] - b_q;
    end

    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        b_d   = b_q;
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, (is_div ? a_in : b_in)};
            rem_d = '0;
            b_d   = is_div ? b_in : a_in;
        end else if (step) begin
            if (is_div) begin
                rem_d = ge ? diff : part[WIDTH-1:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH],
                         acc_q[WIDTH-2:0], ge};
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end else if (fix) begin
            acc_d = '0;
            rem_d = '0;
            b_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            rem_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            b_q   <= b_d;
        end
    end

    always_comb begin
        prod_n = ~acc_q + ONE_2W;
        quo_n  = ~acc_q[WIDTH-1:0] + ONE_W;
        rem_n  = ~rem_q + ONE_W;
        if (is_div) begin
            res_hi = neg_r ? rem_n : rem_q;
            res_lo = neg_q ? quo_n : acc_q[WIDTH-1:0];
        end else begin
            res_hi = neg_q ? prod_n[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];
            res_lo = neg_q ? prod_n[WIDTH-1:0]
                           : acc_q[WIDTH-1:0];
        end
        dvd_o = acc_q[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Mul/div sequencer FSM and HI/LO owner; stalls E only for
// mul/div-class ops that arrive while an operation is in flight.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int               WIDTH   = MD_XLEN,
    parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MD_OPW-1:0] MDOpE,
    input  logic [WIDTH-1:0]  SrcAE,
    input  logic [WIDTH-1:0]  SrcBE,
    input  logic              FlushE,
    output logic              StallMD,
    output logic [WIDTH-1:0]  HiLoE,
    output logic              BusyMD
);

    localparam int             CW    = md_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             div_q, div_d;
    logic             div0_q, div0_d;

    md_op_e           op;
    logic             valid;
    logic             st_go, st_div, st_signed;
    logic             sa, sb, div0;
    logic [WIDTH-1:0] a_op, b_op;
    logic             load, step, fix, it_div;
    logic [WIDTH-1:0] res_hi, res_lo, dvd;

    assign op    = md_op_e'(MDOpE);
    assign valid = (op != MD_NONE) && !FlushE;

    always_comb begin
        st_signed = (op == MD_MULT) || (op == MD_DIV);
        st_div    = (op == MD_DIV) || (op == MD_DIVU);
        st_go     = valid &&
                    (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
        sa        = st_signed & SrcAE[WIDTH-1];
        sb        = st_signed & SrcBE[WIDTH-1];
        div0      = st_div && (SrcBE == '0);
        // Divide-by-zero keeps the raw dividend so HI can return it.
        a_op      = (sa && !div0) ? (~SrcAE + ONE_W) : SrcAE;
        b_op      = sb ? (~SrcBE + ONE_W) : SrcBE;
        it_div    = (state_q == S_IDLE) ? st_div : div_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        div_d   = div_q;
        div0_d  = div0_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (st_go) begin
                    load    = 1'b1;
                    negq_d  = sa ^ sb;
                    negr_d  = sa & st_div;
                    div_d   = st_div;
                    div0_d  = div0;
                    cnt_d   = '0;
                    state_d = div0 ? S_FIX : S_ITER;
                end else if (valid && op == MD_MTHI) begin
                    hi_d = SrcAE;
                end else if (valid && op == MD_MTLO) begin
                    lo_d = SrcAE;
                end
            end
            S_ITER: begin
                step  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                fix     = 1'b1;
                hi_d    = div0_q ? dvd : res_hi;
                lo_d    = div0_q ? DIV0_LO : res_lo;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            div_q   <= div_d;
            div0_q  <= div0_d;
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .fix    (fix),
        .is_div (it_div),
        .neg_q  (negq_q),
        .neg_r  (negr_q),
        .a_in   (a_op),
        .b_in   (b_op),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .dvd_o  (dvd)
    );

    always_comb begin
        BusyMD  = (state_q != S_IDLE);
        StallMD = BusyMD & valid;
        HiLoE   = '0;
        if (state_q == S_IDLE && valid) begin
            if (op == MD_MFHI)      HiLoE = hi_q;
            else if (op == MD_MFLO) HiLoE = lo_q;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: reads push expected HI/LO values,
// a negedge monitor pops and compares whenever a read is served.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   MDOpE = MD_NONE;
    logic [W-1:0] SrcAE = '0;
    logic [W-1:0] SrcBE = '0;
    logic         FlushE = 1'b0;
    logic         StallMD;
    logic [W-1:0] HiLoE;
    logic         BusyMD;

    int           total = 0;
    int           bad = 0;
    int           rd_id = 0;
    logic         rd_en = 1'b0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .MDOpE   (MDOpE),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .FlushE  (FlushE),
        .StallMD (StallMD),
        .HiLoE   (HiLoE),
        .BusyMD  (BusyMD)
    );

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Monitor: a served read is one presented while not stalled.
    always @(negedge clk) begin
        if (rd_en && !StallMD) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                chk($sformatf("read%0d", rd_id), HiLoE, exp_q.pop_front());
            end
            rd_id++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic fl,
                           output int nstall);
        MDOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
        FlushE = fl;
        nstall = 0;
        @(negedge clk);
        while (StallMD && nstall < 200) begin
            nstall++;
            @(negedge clk);
        end
        cyc();
        MDOpE  = MD_NONE;
        FlushE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] op, input logic [W-1:0] exp,
                      input int exp_stall);
        int n;
        exp_q.push_back(exp);
        rd_en = 1'b1;
        present(op, '0, '0, 1'b0, n);
        rd_en = 1'b0;
        chk("read_stall_cycles", 32'(n), 32'(exp_stall));
    endtask

    task automatic start(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int n;
        present(op, a, b, 1'b0, n);
        chk("start_stall", 32'(n), 32'd0);
    endtask

    task automatic wait_idle(input int exp_busy);
        int n;
        n = 0;
        while (BusyMD && n < 200) begin
            n++;
            cyc();
        end
        chk("busy_cycles", 32'(n), 32'(exp_busy));
    endtask

    task automatic mdop(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int busy,
                        input logic [W-1:0] hi, input logic [W-1:0] lo);
        start(op, a, b);
        wait_idle(busy);
        rd(MD_MFHI, hi, 0);
        rd(MD_MFLO, lo, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        chk("rst_busy", 32'(BusyMD), 32'd0);
        chk("rst_stall", 32'(StallMD), 32'd0);
        chk("rst_hilo", HiLoE, 32'd0);
        rd(MD_MFHI, 32'd0, 0);
        rd(MD_MFLO, 32'd0, 0);

        mdop(MD_MULT, 32'hFFFF_FFFD, 32'd7, 33,
             32'hFFFF_FFFF, 32'hFFFF_FFEB);
        mdop(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
             32'hFFFF_FFFE, 32'h0000_0001);
        mdop(MD_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 33,
             32'hC000_0000, 32'h8000_0000);
        mdop(MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        mdop(MD_DIV, 32'hFFFF_FFF9, 32'd2, 33,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);
        mdop(MD_DIV, 32'd7, 32'hFFFF_FFFE, 33,
             32'd1, 32'hFFFF_FFFD);
        mdop(MD_DIVU, 32'hFFFF_FFFF, 32'h10, 33,
             32'hF, 32'h0FFF_FFFF);
        mdop(MD_DIV, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
        mdop(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33,
             32'd0, 32'h8000_0000);

        start(MD_MULT, 32'd6, 32'd7);
        rd(MD_MFLO, 32'd42, 33);
        rd(MD_MFHI, 32'd0, 0);

        start(MD_MULTU, 32'd3, 32'd5);
        @(negedge clk);
        chk("add_nostall", 32'(StallMD), 32'd0);
        chk("add_busy", 32'(BusyMD), 32'd1);
        cyc();
        MDOpE  = MD_MTHI;
        SrcAE  = 32'h1234;
        FlushE = 1'b1;
        @(negedge clk);
        chk("flush_nostall", 32'(StallMD), 32'd0);
        cyc();
        MDOpE  = MD_NONE;
        FlushE = 1'b0;
        wait_idle(31);
        present(MD_MTHI, 32'h1234, 32'd0, 1'b1, n);
        chk("flush_idle_stall", 32'(n), 32'd0);
        rd(MD_MFHI, 32'd0, 0);
        rd(MD_MFLO, 32'd15, 0);

        present(MD_MTHI, 32'hCAFE, 32'd0, 1'b0, n);
        rd(MD_MFHI, 32'hCAFE, 0);
        rd(MD_MFLO, 32'd15, 0);
        present(MD_MTLO, 32'hBEEF, 32'd0, 1'b0, n);
        rd(MD_MFLO, 32'hBEEF, 0);
        rd(MD_MFHI, 32'hCAFE, 0);

        start(MD_MULT, 32'd6, 32'd7);
        present(MD_DIVU, 32'd100, 32'd7, 1'b0, n);
        chk("busy_start_stall", 32'(n), 32'd33);
        wait_idle(33);
        rd(MD_MFHI, 32'd2, 0);
        rd(MD_MFLO, 32'd14, 0);

        start(MD_DIVU, 32'd1000, 32'd3);
        repeat (9) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_busy", 32'(BusyMD), 32'd0);
        chk("midrst_stall", 32'(StallMD), 32'd0);
        rd(MD_MFHI, 32'd0, 0);
        rd(MD_MFLO, 32'd0, 0);
        mdop(MD_MULTU, 32'h1234_5678, 32'h10, 33,
             32'h1, 32'h2345_6780);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
